par_to_ser_arbiter: RTL
=======================

Name: par_to_ser_arbiter

Overview:
- Shares one par_to_ser converter between NUM_REQ parallel-word requesters.
- Arbitrates among the requesters and captures the winner's word.
- Drives the word into the converter's parallel port.
- Monitors the serial handshake to detect frame completion, then grants the next requester.
- Reports which requester owns the serial stream at any time.

Parameters:
- N, 8, word width; must equal the converter's N.
- NUM_REQ, 4, number of requesters (2..16).
- ID_W, $clog2(NUM_REQ), requester index width (derived, localparam).

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- req_data  in  NUM_REQ*N  requester words; requester i occupies bits [i*N +: N]
- req_valid  in  NUM_REQ  per-requester word valid
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high
- cv_par_data  out  N  to converter par_data
- cv_par_valid  out  1  to converter par_valid
- cv_par_ready  in  1  from converter par_ready
- mon_ser_valid  in  1  tap of converter ser_valid
- mon_ser_ready  in  1  tap of sink ser_ready
- owner_id  out  ID_W  requester owning the current frame
- owner_valid  out  1  owner_id meaningful (states LOAD, SHIFT)
- frame_done  out  1  one-cycle pulse when the last bit of a frame is transferred
- done_id  out  ID_W  owner of the completed frame; valid with frame_done

Behaviour:
- Reset values: state=IDLE, rr_ptr=0, hold_reg=0, bit_cnt=0. Outputs req_ready=0, cv_par_valid=0, cv_par_data=0, owner_id=0, owner_valid=0, frame_done=0, done_id=0.
- FSM states: IDLE, LOAD, SHIFT.
- IDLE:
  - winner = first i with req_valid[i], searching from rr_ptr upward with wrap.
  - req_ready[winner]=1 combinationally; all other req_ready bits are 0. With no req_valid bit set, all req_ready bits are 0.
  - On the handshake: hold_reg<=req_data[winner], owner_id<=winner, rr_ptr<=(winner+1) mod NUM_REQ, go to LOAD.
- LOAD:
  - cv_par_valid=1 and cv_par_data=hold_reg, held stable until cv_par_ready.
  - On cv_par_valid&&cv_par_ready: bit_cnt<=0, go to SHIFT.
- SHIFT:
  - cv_par_valid=0; req_ready=0.
  - Each cycle with mon_ser_valid&&mon_ser_ready: bit_cnt<=bit_cnt+1.
  - When that handshake occurs with bit_cnt==N-1: register frame_done=1 and done_id=owner_id for exactly the next cycle, go to IDLE.
- Latency:
  - Requester handshake in cycle T gives cv_par_valid in cycle T+1.
  - The last serial handshake in cycle T gives the frame_done pulse in cycle T+1 and req_ready available again in T+1.
- owner_valid=1 in LOAD and SHIFT; 0 in IDLE.
- ser_ready low mid-frame: bit_cnt holds, no timeout; the frame stretches indefinitely.
- Simultaneous requests: grant order is strict round robin. Example with all requesters valid and rr_ptr=0: grant order 0,1,2,…,NUM_REQ-1,0.
- A requester dropping req_valid without a handshake is a protocol violation; it is not checked and is ignored.
- rr_ptr_wrap: rr_ptr advances modulo NUM_REQ, including non-power-of-2 values.
- Reset mid-frame: immediate return to reset values. The in-flight word is discarded and no frame_done is issued. The converter is reset by the same system reset.
- bit_cnt width: $clog2(N+1); it never exceeds N-1.

Optional Feature:
- Macro: P2S_ARB_FIXED_PRIO_EN.
- Defined: the winner is the lowest-index valid requester (requester 0 highest priority); rr_ptr is not instantiated.
- Undefined: round robin as above.
- All other timing is identical in both builds.

Decomposition:
- par_to_ser_arb_pkg: state enum arb_state_t {IDLE, LOAD, SHIFT}, and function id_width(n) returning $clog2 with a minimum of 1.
- Sub-module rr_arbiter: inputs req vector and rr_ptr; outputs one-hot grant and winner index; purely combinational. The fixed-priority variant is selected inside it under the macro.
- The top level instantiates rr_arbiter. The bench instantiates par_to_ser as the downstream datapath.

Test Plan (N=8, NUM_REQ=3, converter attached, ser_ready=1 unless stated):
- Single request: req 1 valid with 8'd62 -> req_ready[1] for 1 cycle; cv_par_data=62 the next cycle; exactly 8 serial handshakes; frame_done with done_id=1 one cycle after the 8th; owner_valid falls.
- All three requesters valid continuously (words 7, 52, 200) -> grants 0,1,2,0. The serial stream carries 7, then 52, then 200 back to back. done_id sequence is 0,1,2.
- ser_ready low for 3 cycles mid-frame (after bit 3) -> bit_cnt frozen; frame_done delayed by exactly 3 cycles; no second grant while in SHIFT.
- Converter stalls par_ready for 2 cycles -> cv_par_valid and cv_par_data held stable at the captured word; SHIFT is entered only after the handshake.
- rst asserted during bit 5 of a frame -> all outputs return to reset values asynchronously; no frame_done; after release, a pending req 2 is granted first with rr_ptr=0 priority order.
- P2S_ARB_FIXED_PRIO_EN build with reqs 0 and 2 continuously valid -> requester 0 is granted on every arbitration; requester 2 starves.

Source files
------------

// File: rtl/par_to_ser_arb_pkg.sv
// par_to_ser_arb_pkg: arbiter FSM state type and requester-index width helper.
package par_to_ser_arb_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} arb_state_t;
  function automatic int id_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/par_to_ser_arb_if.sv
// par_to_ser_arb_if: requester, converter and serial-monitor signals of par_to_ser_arbiter.
interface par_to_ser_arb_if
  import par_to_ser_arb_pkg::*;
#(
  parameter int N       = 8,
  parameter int NUM_REQ = 4
);
  localparam int ID_W = id_width(NUM_REQ);
  logic [NUM_REQ*N-1:0] req_data;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [N-1:0]         cv_par_data;
  logic                 cv_par_valid;
  logic                 cv_par_ready;
  logic                 mon_ser_valid;
  logic                 mon_ser_ready;
  logic [ID_W-1:0]      owner_id;
  logic                 owner_valid;
  logic                 frame_done;
  logic [ID_W-1:0]      done_id;
  modport slave (
    input  req_data, req_valid, cv_par_ready, mon_ser_valid, mon_ser_ready,
    output req_ready, cv_par_data, cv_par_valid, owner_id, owner_valid, frame_done, done_id
  );
  modport master (
    output req_data, req_valid, cv_par_ready, mon_ser_valid, mon_ser_ready,
    input  req_ready, cv_par_data, cv_par_valid, owner_id, owner_valid, frame_done, done_id
  );
endinterface

// File: rtl/par_to_ser.sv
// par_to_ser: LSB-first parallel-to-serial converter shared by the arbiter's requesters.
module par_to_ser #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] par_data,
  input  logic         par_valid,
  output logic         par_ready,
  output logic         ser_data,
  output logic         ser_valid,
  input  logic         ser_ready
);
  localparam int CW = $clog2(N + 1);
  logic [N-1:0]  sreg;
  logic [CW-1:0] cnt;
  assign ser_valid = cnt != '0;
  assign par_ready = !ser_valid;
  assign ser_data  = sreg[0];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (par_valid && par_ready) begin
      sreg <= par_data;
      cnt  <= CW'(N);
    end else if (ser_valid && ser_ready) begin
      sreg <= sreg >> 1;
      cnt  <= cnt - 1'b1;
    end
  end
endmodule

// File: rtl/par_to_ser_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin picker starting at rr_ptr;
// with P2S_ARB_FIXED_PRIO_EN defined it becomes lowest-index-wins and has no rr_ptr.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
`ifndef P2S_ARB_FIXED_PRIO_EN
  input  logic [ID_W-1:0]    rr_ptr,
`endif
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    winner,
  output logic               found
);
  int idx;
  always_comb begin
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef P2S_ARB_FIXED_PRIO_EN
      idx = k;
`else
      idx = (int'(rr_ptr) + k) % NUM_REQ;
`endif
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        winner     = ID_W'(idx);
        found      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/par_to_ser_arbiter.sv
// par_to_ser_arbiter: shares one par_to_ser converter among NUM_REQ requesters.
// Round robin by default; P2S_ARB_FIXED_PRIO_EN selects fixed priority (requester 0 highest).
module par_to_ser_arbiter
  import par_to_ser_arb_pkg::*;
#(
  parameter int N       = 8,
  parameter int NUM_REQ = 4
) (
  input logic            clk,
  input logic            rst,
  par_to_ser_arb_if.slave bus
);
  localparam int ID_W = id_width(NUM_REQ);
  localparam int CW   = $clog2(N + 1);
  arb_state_t          state, nstate;
  logic [N-1:0]        hold_reg;
  logic [CW-1:0]       bit_cnt;
  logic [ID_W-1:0]     owner_id, done_id, winner;
  logic [NUM_REQ-1:0]  grant;
  logic                found, frame_done, take, load_hs, ser_hs, last;
`ifndef P2S_ARB_FIXED_PRIO_EN
  logic [ID_W-1:0]     rr_ptr;
`endif
  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req   (bus.req_valid),
`ifndef P2S_ARB_FIXED_PRIO_EN
    .rr_ptr(rr_ptr),
`endif
    .grant (grant),
    .winner(winner),
    .found (found)
  );
  assign take    = state == IDLE && found;
  assign load_hs = state == LOAD && bus.cv_par_ready;
  assign ser_hs  = bus.mon_ser_valid && bus.mon_ser_ready;
  assign last    = state == SHIFT && ser_hs && bit_cnt == CW'(N - 1);
  always_comb begin
    nstate = take ? LOAD : load_hs ? SHIFT : last ? IDLE : state;
  end
  assign bus.req_ready    = (state == IDLE) ? grant : '0;
  assign bus.cv_par_valid = state == LOAD;
  assign bus.cv_par_data  = (state == LOAD) ? hold_reg : '0;
  assign bus.owner_id     = owner_id;
  assign bus.owner_valid  = state != IDLE;
  assign bus.frame_done   = frame_done;
  assign bus.done_id      = done_id;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      hold_reg   <= '0;
      bit_cnt    <= '0;
      owner_id   <= '0;
      frame_done <= 1'b0;
      done_id    <= '0;
`ifndef P2S_ARB_FIXED_PRIO_EN
      rr_ptr     <= '0;
`endif
    end else begin
      state      <= nstate;
      frame_done <= last;
      if (last) done_id <= owner_id;
      if (take) begin
        hold_reg <= bus.req_data[int'(winner)*N +: N];
        owner_id <= winner;
`ifndef P2S_ARB_FIXED_PRIO_EN
        rr_ptr   <= (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
`endif
      end
      // counter wraps to 0 on the last bit so it never reaches N
      if (load_hs || last) bit_cnt <= '0;
      else if (state == SHIFT && ser_hs) bit_cnt <= bit_cnt + 1'b1;
    end
  end
endmodule
